// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV-style datapath: sequences fetch, decode, execute,
// memory and writeback, and traps on illegal opcodes or a memory that never answers.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic [1:0]  trap_cause,
    output logic [31:0] inst_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    state_t      cur, nxt;
    logic [1:0]  cause_nxt;
    logic        retire;
    logic [31:0] wait_cnt;
    logic        timeout;
    logic        is_load, is_store, is_branch, is_jump, is_lui, is_op, is_opimm, is_upc, legal;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_op     = (opcode == OPC_OP) || (opcode == OPC_OP32);
    assign is_opimm  = (opcode == OPC_OPIMM) || (opcode == OPC_OPIMM32);
    assign is_upc    = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
    assign legal     = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OPIMM32,
                                      OPC_OP, OPC_OP32};

    // Timeout fires on the cycle that would be the MEM_TIMEOUT-th consecutive wait;
    // a handshake in that same cycle is checked first and therefore wins.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1));
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= FETCH;
            trap_cause <= 2'd0;
            inst_count <= 32'd0;
            wait_cnt   <= 32'd0;
        end else begin
            cur        <= nxt;
            trap_cause <= cause_nxt;
            if (retire)
                inst_count <= inst_count + 32'd1;
            if (mem_req && !mem_ready && (nxt == cur))
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= 32'd0;
        end
    end

    always_comb begin
        nxt       = cur;
        cause_nxt = trap_cause;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end else if (timeout) begin
                    nxt       = TRAP;
                    cause_nxt = 2'd2;
                end
            end
            DECODE: begin
                if (legal) begin
                    nxt = EXEC;
                end else begin
                    nxt       = TRAP;
                    cause_nxt = 2'd1;
                end
            end
            EXEC: begin
                alu_a_sel = is_upc;
                alu_b_sel = !(is_op || is_branch);
                alu_op    = is_branch ? 2'd2 : ((is_op || is_opimm) ? 2'd1 : 2'd0);
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_src = branch_taken ? 2'd1 : 2'd0;
                    retire = 1'b1;
                    nxt    = FETCH;
                end else if (is_load || is_store) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end else if (timeout) begin
                    nxt       = TRAP;
                    cause_nxt = 2'd2;
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
                wb_sel = is_load ? 2'd1 : (is_jump ? 2'd2 : (is_lui ? 2'd3 : 2'd0));
                pc_src = is_jump ? 2'd2 : 2'd0;
            end
            TRAP: begin
                nxt = TRAP;
            end
            default: begin
                nxt       = TRAP;
                cause_nxt = 2'd1;
            end
        endcase
        // Reset kills any in-flight access so nothing retires or strobes during it.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

endmodule
